// File: rtl/pipelined_rca.sv
// Skewed-pipeline ripple-carry adder/subtractor: the carry chain is cut into
// STAGES slices, and each stage adds one slice using the carry registered by the stage before it.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Handshake: a word moves on in_valid && in_ready and leaves on out_valid && out_ready.
  // in_ready is low only while the last stage holds a result that nobody is taking.
  logic stall;

  // Per-stage registers. a_q/b_q carry the operands forward for the slices still to be added.
  // s_q accumulates the finished sum bits. b_q holds B already inverted for subtract.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             o_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             o_d [STAGES];
  logic             v_d [STAGES];

  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  logic carry;
  logic ctop;
  logic abit;
  logic bbit;

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = o_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  always_comb begin
    carry = 1'b0;
    ctop  = 1'b0;
    abit  = 1'b0;
    bbit  = 1'b0;
    // Subtract folds into an add: a + ~b + ~cin.
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub ? ~cin : cin;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
      v_in[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_in[k];
      b_d[k] = b_in[k];
      v_d[k] = v_in[k];
      s_d[k] = s_in[k];
      carry  = c_in[k];
      ctop   = c_in[k];
      for (int i = 0; i < SW; i++) begin
        if (i == SW - 1) ctop = carry;
        abit = a_in[k][k*SW + i];
        bbit = b_in[k][k*SW + i];
        s_d[k][k*SW + i] = abit ^ bbit ^ carry;
        carry = (abit & bbit) | (carry & (abit ^ bbit));
      end
      c_d[k] = carry;
      // Only meaningful in the last stage, where ctop is the carry into bit WIDTH-1.
      o_d[k] = ctop ^ carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        o_q[k] <= o_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, number of register stages; SHALL divide WIDTH exactly, 1 <= STAGES <= WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand word a/b/cin/sub presented this cycle.
REQ-006 in_ready  output  1  block accepts the input word this cycle.
REQ-007 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add mode) / borrow-in (subtract mode).
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result word valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out (add) / not-borrow (subtract).
REQ-015 ovf  output  1  signed overflow flag.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin, full WIDTH+1-bit result.
REQ-018 Subtract mode SHALL compute {cout,sum} = a + ~b + ~cin, i.e. sum = a - b - cin mod 2^WIDTH, cout = 1 iff no borrow.
REQ-019 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, both modes.
REQ-020 Datapath SHALL be a ripple-carry chain split into STAGES slices of WIDTH/STAGES bits; slice k SHALL be computed in stage k using the carry registered from slice k-1.
REQ-021 Operand bits of not-yet-added slices and completed sum bits SHALL be carried forward in per-stage registers (skewed pipeline); no stage SHALL contain a carry path longer than WIDTH/STAGES full-adder cells.
REQ-022 Each stage SHALL hold a valid bit; latency from input transfer to out_valid SHALL be exactly STAGES cycles when not stalled.
REQ-023 Throughput SHALL be one word per cycle with in_valid held high and out_ready held high.
REQ-024 Stall condition: stall = out_valid && !out_ready; while stalled all stage registers and outputs SHALL hold, in_ready SHALL be 0.
REQ-025 in_ready SHALL equal !stall (combinational from out_valid, out_ready); no dependence on in_valid.
REQ-026 Bubbles (in_valid = 0 on an unstalled cycle) SHALL propagate as invalid stages; sum/cout/ovf are don't-care while out_valid = 0 but SHALL not change while out_valid = 1 and stalled.
REQ-027 Word order SHALL be preserved; no word SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-028 sub and cin SHALL be sampled with a/b at input transfer and carried with the word; mixed add/sub streams SHALL be legal back-to-back.
REQ-029 Simultaneous output transfer and input transfer in the same cycle SHALL be legal with the pipeline full.
REQ-030 STAGES = 1 SHALL degenerate to a single registered WIDTH-bit adder with latency 1.

Reset
REQ-031 When rst_n = 0 at a rising clk edge, all stage valid bits SHALL clear; out_valid = 0, sum = 0, cout = 0, ovf = 0 in the following cycle.
REQ-032 Reset SHALL take priority over stall and input transfer; in-flight words SHALL be discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH = 16, STAGES = 4)
REQ-034 Add 0xFFFF + 0x0001, cin 0 -> 4 cycles later sum 0x0000, cout 1, ovf 0.
REQ-035 Add 0x7FFF + 0x0001, cin 0 -> sum 0x8000, cout 0, ovf 1; sub 0x8000 - 0x0001, cin 0 -> sum 0x7FFF, cout 1, ovf 1.
REQ-036 Sub 0x0005 - 0x0007, cin 0 -> sum 0xFFFE, cout 0, ovf 0; sub 0x0005 - 0x0003, cin 1 -> sum 0x0001, cout 1.
REQ-037 Stream 100 random words, out_ready 1 -> first out_valid exactly 4 cycles after first transfer, 100 consecutive results matching a reference model, in_ready constantly 1.
REQ-038 Random out_ready (50%) and in_valid (70%) for 1000 cycles -> in-order, lossless results; sum/cout/ovf stable while out_valid && !out_ready; in_ready = 0 exactly on stall cycles.
REQ-039 Pipeline full, stalled, rst_n pulsed low one cycle -> next cycle out_valid 0, sum 0x0000, cout 0, ovf 0, in_ready 1; no pre-reset word emerges afterwards.
